// File: rtl/writeback_unit.sv
// writeback_unit: drives the register bank's single write port from the ALU and load paths,
// buffers ALU results in a small FIFO while loads hold the port, and tracks pending writes.
// Latency: 1 cycle from winner selection to rf_write; each FIFO entry ahead adds one cycle.
// Backpressure: alu_ready = mem_ready = !fifo_full; a full FIFO drains its head before anything else.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   alu_valid/alu_dr/alu_data     ALU result offer;  alu_ready accepts
//   mem_valid/mem_dr/mem_data     load result offer; mem_ready accepts
//   iss_valid/iss_dr              destination of an instruction issued this cycle
//   pending[31:0]                 bit k set while a write to register k is outstanding
//   rf_write/rf_dr/rf_wrdata      registered register-bank write port
//   fwd_valid/fwd_dr/fwd_data     same-cycle bypass of the selected result
//
// Build option: define WB_FORWARD_EN to build the bypass outputs; otherwise they are tied to 0.

module writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_dr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_dr,
    output logic [31:0] pending,
    output logic        rf_write,
    output logic [4:0]  rf_dr,
    output logic [31:0] rf_wrdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dr,
    output logic [31:0] fwd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // ALU result FIFO storage
    logic [4:0]    fifo_dr   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic alu_fire;
    logic push;
    logic pop;

    // Cycle-N winner
    logic        win_vld;
    logic [4:0]  win_dr;
    logic [31:0] win_data;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // Readiness depends only on occupancy at the start of the cycle, so a full
    // FIFO that pops this cycle still refuses a push.
    assign alu_ready = !fifo_full;
    assign mem_ready = !fifo_full;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        win_vld  = 1'b0;
        win_dr   = '0;
        win_data = '0;
        if (fifo_full) begin
            // Anti-starvation: the oldest ALU result goes before any new load.
            pop      = 1'b1;
            win_vld  = 1'b1;
            win_dr   = fifo_dr[rd_ptr];
            win_data = fifo_data[rd_ptr];
        end else if (mem_valid) begin
            push     = alu_fire;
            win_vld  = 1'b1;
            win_dr   = mem_dr;
            win_data = mem_data;
        end else if (!fifo_empty) begin
            // New ALU result queues behind the head to keep program order.
            pop      = 1'b1;
            push     = alu_fire;
            win_vld  = 1'b1;
            win_dr   = fifo_dr[rd_ptr];
            win_data = fifo_data[rd_ptr];
        end else if (alu_valid) begin
            // Bypass the empty FIFO straight to the port.
            win_vld  = 1'b1;
            win_dr   = alu_dr;
            win_data = alu_data;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dr[wr_ptr]   <= alu_dr;
            fifo_data[wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register-bank write port. r0 results are consumed but never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_write  <= 1'b0;
            rf_dr     <= '0;
            rf_wrdata <= '0;
        end else begin
            rf_write <= win_vld && (win_dr != 5'd0);
            if (win_vld && (win_dr != 5'd0)) begin
                rf_dr     <= win_dr;
                rf_wrdata <= win_data;
            end
        end
    end

    // Pending scoreboard: clear on commit, then set on issue so a same-edge
    // reissue of the committing register leaves its bit set.
    logic [31:0] pending_nxt;

    always_comb begin
        pending_nxt = pending;
        if (rf_write) pending_nxt[rf_dr] = 1'b0;
        if (iss_valid && (iss_dr != 5'd0)) pending_nxt[iss_dr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) pending <= '0;
        else        pending <= pending_nxt;
    end

    // WAW: a register may be reissued only on the edge its earlier write commits.
    waw_check: assert property (@(posedge clk) disable iff (!reset)
        (iss_valid && (iss_dr != 5'd0)) |-> (!pending[iss_dr] || (rf_write && (rf_dr == iss_dr))));

`ifdef WB_FORWARD_EN
    assign fwd_valid = win_vld && (win_dr != 5'd0);
    assign fwd_dr    = win_dr;
    assign fwd_data  = win_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_dr    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vectors against writeback_unit with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are read there as well.
// Ends with a single summary line of error and check counts.

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_dr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_dr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        iss_valid;
    logic [4:0]  iss_dr;
    logic [31:0] pending;
    logic        rf_write;
    logic [4:0]  rf_dr;
    logic [31:0] rf_wrdata;
    logic        fwd_valid;
    logic [4:0]  fwd_dr;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_dr(alu_dr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_dr(iss_dr), .pending(pending),
        .rf_write(rf_write), .rf_dr(rf_dr), .rf_wrdata(rf_wrdata),
        .fwd_valid(fwd_valid), .fwd_dr(fwd_dr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] dr, input logic [31:0] data);
        chk({tag, ".write"}, 32'(rf_write), 32'd1);
        chk({tag, ".dr"}, 32'(rf_dr), 32'(dr));
        chk({tag, ".data"}, rf_wrdata, data);
    endtask

    initial begin
        reset = 1'b0;
        alu_valid = 1'b0; alu_dr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dr = '0; mem_data = '0;
        iss_valid = 1'b0; iss_dr = '0;

        // Reset held two cycles with an ALU offer present
        alu_valid = 1'b1; alu_dr = 5'd9; alu_data = 32'h1;
        tick();
        tick();
        chk("rst.write", 32'(rf_write), 32'd0);
        chk("rst.pending", pending, 32'd0);
        chk("rst.dr", 32'(rf_dr), 32'd0);
        chk("rst.data", rf_wrdata, 32'd0);
        alu_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst.alu_ready", 32'(alu_ready), 32'd1);
        chk("rst.mem_ready", 32'(mem_ready), 32'd1);

        // Single ALU result with prior issue to r5
        iss_valid = 1'b1; iss_dr = 5'd5;
        tick();
        iss_valid = 1'b0;
        chk("single.pend_set", pending, 32'h0000_0020);
        alu_valid = 1'b1; alu_dr = 5'd5; alu_data = 32'h0000_00AB;
        #1;
`ifdef WB_FORWARD_EN
        chk("single.fwd_valid", 32'(fwd_valid), 32'd1);
        chk("single.fwd_data", fwd_data, 32'h0000_00AB);
`else
        chk("single.fwd_off", 32'(fwd_valid), 32'd0);
`endif
        tick();
        alu_valid = 1'b0;
        chk_wr("single", 5'd5, 32'h0000_00AB);
        chk("single.pend_hold", pending, 32'h0000_0020);
        tick();
        chk("single.idle", 32'(rf_write), 32'd0);
        chk("single.pend_clr", pending, 32'd0);

        // Collision: load wins, ALU result follows one cycle later
        mem_valid = 1'b1; mem_dr = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_dr = 5'd4; alu_data = 32'h22;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk_wr("coll.n1", 5'd3, 32'h11);
        tick();
        chk_wr("coll.n2", 5'd4, 32'h22);
        tick();
        chk("coll.idle", 32'(rf_write), 32'd0);

        // Backpressure: loads held high while three ALU results queue up
        mem_valid = 1'b1; mem_dr = 5'd10; mem_data = 32'h100;
        alu_valid = 1'b1; alu_dr = 5'd1; alu_data = 32'hA1;
        tick();
        chk_wr("bp.c1", 5'd10, 32'h100);
        mem_dr = 5'd11; mem_data = 32'h101;
        alu_dr = 5'd2; alu_data = 32'hA2;
        tick();
        chk_wr("bp.c2", 5'd11, 32'h101);
        mem_dr = 5'd12; mem_data = 32'h102;
        alu_dr = 5'd3; alu_data = 32'hA3;
        #1;
        chk("bp.full_alu_ready", 32'(alu_ready), 32'd0);
        chk("bp.full_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        chk_wr("bp.c3", 5'd1, 32'hA1);
        chk("bp.alu_ready_back", 32'(alu_ready), 32'd1);
        chk("bp.mem_ready_back", 32'(mem_ready), 32'd1);
        tick();
        chk_wr("bp.c4", 5'd12, 32'h102);
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        chk_wr("bp.c5", 5'd2, 32'hA2);
        tick();
        chk_wr("bp.c6", 5'd3, 32'hA3);
        tick();
        chk("bp.idle", 32'(rf_write), 32'd0);

        // r0 result is consumed without a write
        alu_valid = 1'b1; alu_dr = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        chk("r0.alu_ready", 32'(alu_ready), 32'd1);
        chk("r0.fwd_valid", 32'(fwd_valid), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("r0.write", 32'(rf_write), 32'd0);
        chk("r0.pend0", 32'(pending[0]), 32'd0);

        // Set/clear race on r7
        iss_valid = 1'b1; iss_dr = 5'd7;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_dr = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        chk_wr("race.commit", 5'd7, 32'h77);
        iss_valid = 1'b1; iss_dr = 5'd7;
        tick();
        iss_valid = 1'b0;
        chk("race.pend7", pending, 32'h0000_0080);
        chk("race.idle", 32'(rf_write), 32'd0);

        // Reset mid-operation with a full FIFO
        mem_valid = 1'b1; mem_dr = 5'd13; mem_data = 32'h130;
        alu_valid = 1'b1; alu_dr = 5'd21; alu_data = 32'h210;
        tick();
        mem_dr = 5'd14; mem_data = 32'h140;
        alu_dr = 5'd22; alu_data = 32'h220;
        tick();
        chk_wr("mid.pre", 5'd14, 32'h140);
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("mid.full", 32'(alu_ready), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid.rst_write", 32'(rf_write), 32'd0);
        chk("mid.rst_pending", pending, 32'd0);
        reset = 1'b1;
        #1;
        chk("mid.empty", 32'(alu_ready), 32'd1);
        tick();
        chk("mid.no_drain1", 32'(rf_write), 32'd0);
        tick();
        chk("mid.no_drain2", 32'(rf_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side driver for the processor's 32x32 register bank. Collects results from the ALU path and the load path, arbitrates them onto the bank's single write port (write/dr/wrData), and buffers ALU results in a small FIFO when the load path holds the port. Also keeps a per-register pending scoreboard that the issue/decode stage uses to stall reads of registers whose writes have not yet committed.

## Interface
- DEPTH, 2: ALU result FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low; state cleared on any posedge with reset==0
- alu_valid  in  1  ALU result offered this cycle
- alu_dr  in  5  ALU destination register
- alu_data  in  32  ALU result, signed
- alu_ready  out  1  ALU result accepted this cycle (=!fifo_full)
- mem_valid  in  1  load result offered; held stable until mem_ready
- mem_dr  in  5  load destination register
- mem_data  in  32  load result, signed
- mem_ready  out  1  load result accepted this cycle
- iss_valid  in  1  instruction with a destination issued this cycle
- iss_dr  in  5  its destination register
- pending  out  32  bit k=1: write to register k outstanding
- rf_write  out  1  register bank write enable, registered
- rf_dr  out  5  register bank destination, registered
- rf_wrdata  out  32  register bank write data, registered
- fwd_valid  out  1  bypass: result selected this cycle
- fwd_dr  out  5  bypass destination
- fwd_data  out  32  bypass data

## Operation
- Reset: FIFO empty, pending=0, rf_write=0, rf_dr=0, rf_wrdata=0; alu_ready=1 and mem_ready=1 in the first cycle after reset release.
- ALU transfer occurs when alu_valid && alu_ready; result is pushed to the FIFO, or bypasses it (same cycle selection) when FIFO is empty and the port is free.
- Port arbitration each cycle, one winner:
  - FIFO full: FIFO head wins, mem_ready=0 (anti-starvation).
  - Otherwise mem_valid: load wins, mem_ready=1; ALU result pushed to FIFO.
  - Otherwise FIFO non-empty: head wins; new ALU result pushed behind it (order preserved).
  - Otherwise alu_valid: ALU result wins directly.
- mem_ready is combinational from FIFO occupancy; alu_ready = !full; a full FIFO popping this cycle still reports full (no same-cycle push-on-pop).
- Winner with dr==0: consumed, rf_write stays 0 next cycle (r0 never written).
- Scoreboard: set pending[iss_dr] on iss_valid (dr≠0); clear pending[rf_dr] on an edge where rf_write==1. Set and clear of the same index on one edge: set wins. pending[0] is constant 0.
- Issue stage must not issue a second write to a register whose pending bit is set (WAW); asserted in simulation.
- Reset mid-operation: FIFO contents and in-flight write dropped, pending cleared, no rf_write pulse after reset edge.

## Timing
- Winner selected in cycle N → rf_write/rf_dr/rf_wrdata valid in cycle N+1 → bank captures at end of N+1, pending bit clears on that same edge.
- ALU result via empty FIFO and free port: 1-cycle latency to rf_write; each FIFO entry ahead adds one cycle.
- Sustained throughput: one register write per cycle.
- Two consecutive writes to different registers produce back-to-back rf_write pulses with no bubble.

## Configuration
- WB_FORWARD_EN defined: fwd_valid/fwd_dr/fwd_data combinationally reflect the cycle-N winner (fwd_valid=0 for dr==0), one cycle ahead of rf_write, for decode-stage bypass.
- Undefined: fwd_valid, fwd_dr, fwd_data tied to 0; no bypass logic built.

## Test plan
- Reset: hold reset=0 two cycles with alu_valid=1 → rf_write=0, pending=0, rf_dr=0, rf_wrdata=0; after release alu_ready=1, mem_ready=1.
- Single ALU: alu_valid, dr=5, data=0x0000_00AB with iss_valid dr=5 one cycle earlier → rf_write=1 dr=5 data=0xAB next cycle; pending[5] drops on that edge.
- Collision: same cycle mem(dr=3,0x11) and alu(dr=4,0x22) → cycle N+1 writes r3=0x11, N+2 writes r4=0x22.
- Backpressure: mem_valid held high with 3 ALU results → FIFO fills, alu_ready=0, mem_ready=0 for one cycle while head drains; all 3 ALU writes appear in issue order.
- r0: alu dr=0 data=0xFFFF_FFFF → alu_ready=1, no rf_write pulse, pending[0]=0; with WB_FORWARD_EN fwd_valid=0.
- Set/clear race: iss_valid dr=7 on the edge rf_write commits r7 → pending[7]=1 afterwards.
